// File: rtl/axi_dma_mc_frontend.sv
// Multi-channel request front-end for the 1D DMA backend: per-channel FIFOs, round-robin issue
// through a one-entry output stage, in-order completion routing. Option: AXI_DMA_MC_PRIO_EN.
module axi_dma_mc_frontend #(
  parameter int unsigned  NUM_CHANNELS    = 4,
  parameter int unsigned  REQ_FIFO_DEPTH  = 4,
  parameter int unsigned  MAX_OUTSTANDING = 4,
  parameter int unsigned  TAG_FIFO_DEPTH  = 8,
  parameter type          burst_req_t     = logic [31:0],
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned CH_W            = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  burst_req_t              ch_req_i         [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] ch_valid_i,
`ifdef AXI_DMA_MC_PRIO_EN
  input  logic [NUM_CHANNELS-1:0] ch_prio_i,
`endif
  output logic [NUM_CHANNELS-1:0] ch_ready_o,
  output logic [NUM_CHANNELS-1:0] ch_complete_o,
  output logic [CNT_W-1:0]        ch_outstanding_o [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] ch_idle_o,
  output burst_req_t              be_req_o,
  output logic                    be_valid_o,
  input  logic                    be_ready_i,
  input  logic                    be_complete_i,
  input  logic                    be_idle_i,
  output logic                    idle_o,
  output logic                    err_o
);

  localparam int unsigned RPW = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int unsigned RCW = $clog2(REQ_FIFO_DEPTH + 1);
  localparam int unsigned TPW = (TAG_FIFO_DEPTH > 1) ? $clog2(TAG_FIFO_DEPTH) : 1;
  localparam int unsigned TCW = $clog2(TAG_FIFO_DEPTH + 1);

  burst_req_t        fifo_mem_q  [NUM_CHANNELS][REQ_FIFO_DEPTH];
  logic [RPW-1:0]    fifo_wptr_q [NUM_CHANNELS];
  logic [RPW-1:0]    fifo_rptr_q [NUM_CHANNELS];
  logic [RCW-1:0]    fifo_cnt_q  [NUM_CHANNELS];
  logic [CH_W-1:0]   tag_mem_q   [TAG_FIFO_DEPTH];
  logic [TPW-1:0]    tag_wptr_q, tag_rptr_q;
  logic [TCW-1:0]    tag_cnt_q;
  logic              stage_valid_q;
  burst_req_t        stage_req_q;
  logic [CH_W-1:0]   stage_ch_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CHANNELS];
  logic [CNT_W-1:0]  cnt_d [NUM_CHANNELS];
  logic [CH_W-1:0]   rr_q;
  logic [NUM_CHANNELS-1:0] complete_q, complete_d;
  logic              err_q;

  logic [NUM_CHANNELS-1:0] fifo_full, fifo_empty, push, pop, staged_for, elig, cand;
  logic              handshake, load, tag_room, win_valid, comp_valid;
  logic [CH_W-1:0]   win_ch, comp_ch;
  int unsigned       arb_idx;

  function automatic logic [RPW-1:0] rptr_inc(input logic [RPW-1:0] p);
    return (p == RPW'(REQ_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TPW-1:0] tptr_inc(input logic [TPW-1:0] p);
    return (p == TPW'(TAG_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign handshake  = stage_valid_q && be_ready_i;
  assign comp_valid = be_complete_i && (tag_cnt_q != '0);
  assign comp_ch    = tag_mem_q[tag_rptr_q];
  // The staged entry already owns a tag slot, so it counts against the tag FIFO.
  assign tag_room   = ({1'b0, tag_cnt_q} + {{TCW{1'b0}}, stage_valid_q})
                      < (TCW + 1)'(TAG_FIFO_DEPTH);

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      fifo_full[c]  = (fifo_cnt_q[c] == RCW'(REQ_FIFO_DEPTH));
      fifo_empty[c] = (fifo_cnt_q[c] == '0);
      push[c]       = ch_valid_i[c] && !fifo_full[c];
      staged_for[c] = stage_valid_q && (stage_ch_q == CH_W'(c));
      elig[c]       = !fifo_empty[c] && tag_room &&
                      (({1'b0, cnt_q[c]} + {{CNT_W{1'b0}}, staged_for[c]})
                       < (CNT_W + 1)'(MAX_OUTSTANDING));
    end
  end

  always_comb begin
    cand      = elig;
`ifdef AXI_DMA_MC_PRIO_EN
    if (|(elig & ch_prio_i)) cand = elig & ch_prio_i;
`endif
    win_valid = 1'b0;
    win_ch    = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      arb_idx = (32'(rr_q) + i) % NUM_CHANNELS;
      if (!win_valid && cand[arb_idx]) begin
        win_valid = 1'b1;
        win_ch    = CH_W'(arb_idx);
      end
    end
  end

  assign load = win_valid && (!stage_valid_q || handshake);

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pop[c]        = load && (win_ch == CH_W'(c));
      complete_d[c] = comp_valid && (comp_ch == CH_W'(c));
      cnt_d[c]      = cnt_q[c];
      if (handshake && staged_for[c]) cnt_d[c] = cnt_d[c] + 1'b1;
      if (complete_d[c])              cnt_d[c] = cnt_d[c] - 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters below.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) fifo_mem_q[c][fifo_wptr_q[c]] <= ch_req_i[c];
    end
    if (handshake) tag_mem_q[tag_wptr_q] <= stage_ch_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        fifo_wptr_q[c] <= '0;
        fifo_rptr_q[c] <= '0;
        fifo_cnt_q[c]  <= '0;
        cnt_q[c]       <= '0;
      end
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      tag_cnt_q     <= '0;
      stage_valid_q <= 1'b0;
      stage_req_q   <= '0;
      stage_ch_q    <= '0;
      rr_q          <= '0;
      complete_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (push[c]) fifo_wptr_q[c] <= rptr_inc(fifo_wptr_q[c]);
        if (pop[c])  fifo_rptr_q[c] <= rptr_inc(fifo_rptr_q[c]);
        fifo_cnt_q[c] <= fifo_cnt_q[c] + RCW'(push[c]) - RCW'(pop[c]);
        cnt_q[c]      <= cnt_d[c];
      end
      if (handshake)  tag_wptr_q <= tptr_inc(tag_wptr_q);
      if (comp_valid) tag_rptr_q <= tptr_inc(tag_rptr_q);
      tag_cnt_q <= tag_cnt_q + TCW'(handshake) - TCW'(comp_valid);
      if (load) begin
        stage_valid_q <= 1'b1;
        stage_req_q   <= fifo_mem_q[win_ch][fifo_rptr_q[win_ch]];
        stage_ch_q    <= win_ch;
        rr_q          <= (win_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : win_ch + 1'b1;
      end else if (handshake) begin
        stage_valid_q <= 1'b0;
      end
      complete_q <= complete_d;
      if (be_complete_i && (tag_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  assign ch_ready_o       = ~fifo_full;
  assign ch_complete_o    = complete_q;
  assign ch_outstanding_o = cnt_q;
  assign be_req_o         = stage_req_q;
  assign be_valid_o       = stage_valid_q;
  assign err_o            = err_q;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_idle_o[c] = fifo_empty[c] && (cnt_q[c] == '0) && !staged_for[c];
    end
  end

  assign idle_o = (&ch_idle_o) && !stage_valid_q && be_idle_i;

endmodule

// File: tb/tb_axi_dma_mc_frontend.sv
// Directed self-checking bench for axi_dma_mc_frontend (4 channels, default depths).
module tb_axi_dma_mc_frontend;
  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch_req [N];
  logic [N-1:0] ch_valid, ch_ready, ch_complete, ch_idle;
`ifdef AXI_DMA_MC_PRIO_EN
  logic [N-1:0] ch_prio;
`endif
  logic [2:0]  ch_out [N];
  logic [31:0] be_req;
  logic        be_valid, be_ready, be_complete, be_idle, idle, err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_base;

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && be_valid && be_ready) hs_cnt <= hs_cnt + 1;

  axi_dma_mc_frontend dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ch_req_i         (ch_req),
    .ch_valid_i       (ch_valid),
`ifdef AXI_DMA_MC_PRIO_EN
    .ch_prio_i        (ch_prio),
`endif
    .ch_ready_o       (ch_ready),
    .ch_complete_o    (ch_complete),
    .ch_outstanding_o (ch_out),
    .ch_idle_o        (ch_idle),
    .be_req_o         (be_req),
    .be_valid_o       (be_valid),
    .be_ready_i       (be_ready),
    .be_complete_i    (be_complete),
    .be_idle_i        (be_idle),
    .idle_o           (idle),
    .err_o            (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input int k);
    return 32'(c * 256 + k);
  endfunction

  function automatic logic [11:0] outs();
    return {ch_out[3], ch_out[2], ch_out[1], ch_out[0]};
  endfunction

  initial begin
    rst         = 1'b1;
    ch_valid    = '0;
    be_ready    = 1'b0;
    be_complete = 1'b0;
    be_idle     = 1'b1;
`ifdef AXI_DMA_MC_PRIO_EN
    ch_prio     = '0;
`endif
    for (int c = 0; c < N; c++) ch_req[c] = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_be_valid", be_valid, 0);
    chk("rst_ch_ready", ch_ready, 4'hf);
    chk("rst_ch_idle", ch_idle, 4'hf);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_be_req", be_req, 0);
    chk("rst_complete", ch_complete, 0);
    chk("rst_outstanding", outs(), 0);

    // All channels push two requests; round-robin order to the backend
    be_ready = 1'b1;
    ch_valid = 4'hf;
    for (int c = 0; c < N; c++) ch_req[c] = mk(c, 0);
    step();
    chk("rr_latency", be_valid, 0);
    for (int c = 0; c < N; c++) ch_req[c] = mk(c, 1);
    step();
    ch_valid = '0;
    for (int i = 0; i < 8; i++) begin
      chk("rr_valid", be_valid, 1);
      chk("rr_order", be_req, mk(i % 4, i / 4));
      step();
    end
    chk("rr_drained", be_valid, 0);
    chk("rr_outstanding", outs(), {3'd2, 3'd2, 3'd2, 3'd2});
    be_complete = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_complete", ch_complete, 64'(1) << (i % 4));
    end
    be_complete = 1'b0;
    step();
    chk("rr_complete_end", ch_complete, 0);
    chk("rr_outstanding_end", outs(), 0);
    chk("rr_idle_end", ch_idle, 4'hf);
    chk("rr_err", err, 0);

    // Outstanding cap on one channel
    hs_base  = hs_cnt;
    ch_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      ch_req[1] = mk(1, k);
      chk("cap_ready", ch_ready[1], 1);
      step();
    end
    ch_valid = '0;
    step();
    step();
    chk("cap_issued", 64'(hs_cnt - hs_base), 4);
    chk("cap_outstanding", ch_out[1], 4);
    chk("cap_stall", be_valid, 0);
    be_complete = 1'b1;
    step();
    be_complete = 1'b0;
    chk("cap_pulse", ch_complete, 4'b0010);
    chk("cap_dec", ch_out[1], 3);
    step();
    chk("cap_fifth_valid", be_valid, 1);
    chk("cap_fifth_req", be_req, mk(1, 4));
    chk("cap_pulse_gone", ch_complete, 0);
    step();
    chk("cap_full_again", ch_out[1], 4);
    chk("cap_issued5", 64'(hs_cnt - hs_base), 5);
    chk("cap_stall2", be_valid, 0);

    // Reset mid-operation flushes everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_outstanding", outs(), 0);
    chk("flush_idle", ch_idle, 4'hf);
    chk("flush_valid", be_valid, 0);
    chk("flush_ready", ch_ready, 4'hf);

    // Backpressure with ch2 staged
    be_ready  = 1'b0;
    ch_valid  = 4'b0100;
    ch_req[2] = mk(2, 0);
    step();
    ch_req[2] = mk(2, 1);
    step();
    chk("bp_valid", be_valid, 1);
    chk("bp_req", be_req, mk(2, 0));
    ch_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      ch_req[2] = mk(2, k + 2);
      ch_req[0] = mk(0, k);
      if (k == 3) ch_valid = 4'b0100;
      step();
      chk("bp_hold_req", be_req, mk(2, 0));
      chk("bp_hold_valid", be_valid, 1);
    end
    chk("bp_ready", ch_ready, 4'b1011);
    ch_valid = '0;
    be_ready = 1'b1;
    step();
    chk("bp_wrap_ch0", be_req, mk(0, 0));
    step();
    chk("bp_ch2_order", be_req, mk(2, 1));
    step();
    chk("bp_ch0_second", be_req, mk(0, 1));
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Completion in the same cycle as a handshake of the same channel
    ch_valid = 4'b1000;
    ch_req[3] = mk(3, 0);
    step();
    ch_req[3] = mk(3, 1);
    step();
    ch_req[3] = mk(3, 2);
    step();
    ch_valid = '0;
    step();
    chk("same_out_before", ch_out[3], 2);
    chk("same_staged", be_req, mk(3, 2));
    be_complete = 1'b1;
    step();
    chk("same_out_after", ch_out[3], 2);
    chk("same_pulse", ch_complete, 4'b1000);
    chk("same_valid", be_valid, 0);

    // Drain, then a completion with nothing in flight
    step();
    step();
    chk("drain_err", err, 0);
    chk("drain_out", ch_out[3], 0);
    chk("drain_pulse", ch_complete, 4'b1000);
    step();
    chk("empty_err", err, 1);
    chk("empty_no_pulse", ch_complete, 0);
    be_complete = 1'b0;
    step();
    step();
    chk("err_sticky", err, 1);
    chk("err_no_pulse", ch_complete, 0);
    chk("idle_all", idle, 1);
    be_idle = 1'b0;
    #1;
    chk("idle_be_busy", idle, 0);
    be_idle = 1'b1;

`ifdef AXI_DMA_MC_PRIO_EN
    // Priority channel wins every grant while eligible
    rst = 1'b1;
    step();
    rst      = 1'b0;
    ch_prio  = 4'b0100;
    ch_valid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < N; c++) ch_req[c] = mk(c, k);
      step();
      if (k >= 1) chk("prio_win", be_req, mk(2, k - 1));
    end
    ch_valid = '0;
    step();
    chk("prio_win_last", be_req, mk(2, 3));
    step();
    chk("prio_capped", be_req, mk(3, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
